vga_sync_gen: RTL and testbench

Display timing generator for the minesweeper VGA path. It consumes the pixel-rate enable produced by the clock divider and advances the 640x480@60 Hz horizontal and vertical raster counters. It drives the monitor sync pins and gives the board renderer the current pixel coordinate, a visible-area flag and a start-of-frame strobe. The block runs entirely on the master clock; the pixel rate is expressed only as an enable, never as a derived clock.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_sync_gen_if.sv | 30 +++
 rtl/vga_axis_counter.sv | 67 ++++++
 rtl/vga_sync_gen.sv | 97 +++++++++
 tb/tb_vga_sync_gen.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 Hz timing defaults, phase enum, coordinate type.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    typedef logic [9:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Pixel enable in, sync pins and raster position out.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   pix_en;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    coord_t hcount;
    coord_t vcount;
    logic   frame_start;

    // The timing generator owns the raster; the consumer supplies the enable.
    modport master (
        input  pix_en,
        output hsync, vsync, video_on, hcount, vcount, frame_start
    );

    modport slave (
        output pix_en,
        input  hsync, vsync, video_on, hcount, vcount, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK
//               phase FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE_LEN = 640,
    parameter int FRONT_LEN   = 16,
    parameter int SYNC_LEN    = 96,
    parameter int BACK_LEN    = 48
) (
    input  logic   master,
    input  logic   rst,
    input  logic   inc,
    output coord_t count,
    output phase_t phase,
    output logic   wrap
);

    localparam int     c_total    = VISIBLE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam coord_t c_last     = coord_t'(c_total - 1);
    localparam coord_t c_front_at = coord_t'(VISIBLE_LEN);
    localparam coord_t c_sync_at  = coord_t'(VISIBLE_LEN + FRONT_LEN);
    localparam coord_t c_back_at  = coord_t'(VISIBLE_LEN + FRONT_LEN + SYNC_LEN);

    coord_t r_count;
    coord_t w_count_nxt;
    phase_t r_phase;
    phase_t w_phase_nxt;

    assign wrap  = (r_count == c_last);
    assign count = r_count;
    // Exposes the phase being entered on this edge so the top can register
    // its sync outputs in lockstep with the count.
    assign phase = w_phase_nxt;

    always_comb begin
        w_count_nxt = r_count;
        w_phase_nxt = r_phase;
        if (inc) begin
            w_count_nxt = wrap ? '0 : r_count + 10'd1;
            case (r_phase)
                ACTIVE:  if (w_count_nxt == c_front_at) w_phase_nxt = FRONT;
                FRONT:   if (w_count_nxt == c_sync_at)  w_phase_nxt = SYNC;
                SYNC:    if (w_count_nxt == c_back_at)  w_phase_nxt = BACK;
                BACK:    if (w_count_nxt == '0)         w_phase_nxt = ACTIVE;
                default: w_phase_nxt = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge master or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_phase <= ACTIVE;
        end else begin
            r_count <= w_count_nxt;
            r_phase <= w_phase_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : 640x480@60 Hz raster timing generator driven by a pixel enable.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic           master,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    logic   r_armed;
    logic   w_en;
    logic   w_v_inc;
    coord_t w_hcount;
    coord_t w_vcount;
    phase_t w_h_phase;
    phase_t w_v_phase;
    logic   w_h_wrap;
    logic   w_v_wrap;

    logic   r_hsync;
    logic   r_vsync;
    logic   r_video_on;
    logic   r_frame_start;

    // r_armed blocks a pix_en that lands in the cycle reset is released.
    assign w_en    = vga.pix_en & r_armed;
    assign w_v_inc = w_en & w_h_wrap;

    vga_axis_counter #(
        .VISIBLE_LEN (H_VISIBLE),
        .FRONT_LEN   (H_FRONT),
        .SYNC_LEN    (H_SYNC),
        .BACK_LEN    (H_BACK)
    ) u_h_axis (
        .master (master),
        .rst    (rst),
        .inc    (w_en),
        .count  (w_hcount),
        .phase  (w_h_phase),
        .wrap   (w_h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE_LEN (V_VISIBLE),
        .FRONT_LEN   (V_FRONT),
        .SYNC_LEN    (V_SYNC),
        .BACK_LEN    (V_BACK)
    ) u_v_axis (
        .master (master),
        .rst    (rst),
        .inc    (w_v_inc),
        .count  (w_vcount),
        .phase  (w_v_phase),
        .wrap   (w_v_wrap)
    );

    always_ff @(posedge master or negedge rst) begin
        if (!rst) begin
            r_armed       <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_armed       <= 1'b1;
            r_frame_start <= w_en & w_h_wrap & w_v_wrap;
            if (w_en) begin
                r_hsync    <= (w_h_phase != SYNC);
                r_vsync    <= (w_v_phase != SYNC);
                r_video_on <= (w_h_phase == ACTIVE) && (w_v_phase == ACTIVE);
            end
        end
    end

    assign vga.hcount      = w_hcount;
    assign vga.vcount      = w_vcount;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.video_on    = r_video_on;
    assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Randomised self-checking bench for vga_sync_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    // Instance A uses the 640x480 defaults; instance B uses a shrunken raster
    // so whole frames fit in a short run.
    localparam int c_ah_v = 640, c_ah_f = 16, c_ah_s = 96, c_ah_b = 48;
    localparam int c_av_v = 480, c_av_f = 10, c_av_s = 2,  c_av_b = 33;
    localparam int c_bh_v = 40,  c_bh_f = 4,  c_bh_s = 8,  c_bh_b = 6;
    localparam int c_bv_v = 20,  c_bv_f = 3,  c_bv_s = 2,  c_bv_b = 4;
    localparam int c_a_frame = 800 * 525;
    localparam int c_b_ht    = 58;
    localparam int c_b_frame = 58 * 29;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    vga_sync_gen_if bus_a ();
    vga_sync_gen_if bus_b ();

    vga_sync_gen u_dut_a (
        .master (clk),
        .rst    (rst_a),
        .vga    (bus_a)
    );

    vga_sync_gen #(
        .H_VISIBLE (c_bh_v), .H_FRONT (c_bh_f), .H_SYNC (c_bh_s), .H_BACK (c_bh_b),
        .V_VISIBLE (c_bv_v), .V_FRONT (c_bv_f), .V_SYNC (c_bv_s), .V_BACK (c_bv_b)
    ) u_dut_b (
        .master (clk),
        .rst    (rst_b),
        .vga    (bus_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: p counts accepted pixel enables since reset; position follows.
    int pa = 0, pb = 0;
    bit arm_a = 1'b0, arm_b = 1'b0;
    bit fs_a = 1'b0, fs_b = 1'b0;

    function automatic logic [23:0] exp_vec(input int p, input bit fs,
                                            input int hv, input int hf, input int hs, input int hb,
                                            input int vv, input int vf, input int vs, input int vb);
        int   ht, vt, h, v;
        logic hsy, vsy, vo;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        h   = p % ht;
        v   = (p / ht) % vt;
        hsy = !(h >= hv + hf && h < hv + hf + hs);
        vsy = !(v >= vv + vf && v < vv + vf + vs);
        vo  = (p > 0) && (h < hv) && (v < vv);
        return {h[9:0], v[9:0], hsy, vsy, vo, fs};
    endfunction

    function automatic logic [23:0] exp_a();
        return exp_vec(pa, fs_a, c_ah_v, c_ah_f, c_ah_s, c_ah_b, c_av_v, c_av_f, c_av_s, c_av_b);
    endfunction

    function automatic logic [23:0] exp_b();
        return exp_vec(pb, fs_b, c_bh_v, c_bh_f, c_bh_s, c_bh_b, c_bv_v, c_bv_f, c_bv_s, c_bv_b);
    endfunction

    function automatic logic [23:0] obs_a();
        return {bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync, bus_a.video_on, bus_a.frame_start};
    endfunction

    function automatic logic [23:0] obs_b();
        return {bus_b.hcount, bus_b.vcount, bus_b.hsync, bus_b.vsync, bus_b.video_on, bus_b.frame_start};
    endfunction

    // One master cycle for both instances; returns at posedge + 1.
    task automatic step(input bit en_a, input bit en_b);
        bit fire;
        bus_a.pix_en = en_a;
        bus_b.pix_en = en_b;
        @(posedge clk);
        fire  = arm_a && en_a && rst_a;
        if (fire) pa++;
        fs_a  = fire && (pa % c_a_frame == 0);
        arm_a = rst_a;
        fire  = arm_b && en_b && rst_b;
        if (fire) pb++;
        fs_b  = fire && (pb % c_b_frame == 0);
        arm_b = rst_b;
        #1;
    endtask

    task automatic advance_b_to(input int target);
        for (int i = 0; i < c_b_frame + 2 && (pb % c_b_frame) != target; i++) step(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        pa = 0; pb = 0; arm_a = 0; arm_b = 0; fs_a = 0; fs_b = 0;
        #1;
        total++;
        if (obs_a() !== exp_a()) begin
            bad++; $display("FAIL reset_a actual=%h required=%h", obs_a(), exp_a());
        end
        total++;
        if (obs_b() !== exp_b()) begin
            bad++; $display("FAIL reset_b actual=%h required=%h", obs_b(), exp_b());
        end
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        // pix_en in the release cycle must be ignored.
        step(1'b1, 1'b1);
        total++;
        if (obs_a() !== exp_a() || bus_a.video_on !== 1'b0) begin
            bad++; $display("FAIL release_ignore_a actual=%h required=%h", obs_a(), exp_a());
        end
        total++;
        if (obs_b() !== exp_b() || bus_b.video_on !== 1'b0) begin
            bad++; $display("FAIL release_ignore_b actual=%h required=%h", obs_b(), exp_b());
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_line_wrap();
        int lows = 0, min_h = 1023, max_h = 0, vis = 0;
        for (int i = 0; i < 3200; i++) begin
            bit en;
            en = (i % 4 == 3);
            step(en, 1'b0);
            total++;
            if (obs_a() !== exp_a()) begin
                bad++; $display("FAIL line_a step=%0d actual=%h required=%h", i, obs_a(), exp_a());
            end
            if (en && bus_a.hsync === 1'b0) begin
                lows++;
                if (int'(bus_a.hcount) < min_h) min_h = int'(bus_a.hcount);
                if (int'(bus_a.hcount) > max_h) max_h = int'(bus_a.hcount);
            end
            if (en && bus_a.video_on === 1'b1 && bus_a.vcount == 10'd0) vis++;
        end
        total++;
        if (bus_a.hcount !== 10'd0 || bus_a.vcount !== 10'd1) begin
            bad++; $display("FAIL line_wrap_pos actual=(%0d,%0d) required=(0,1)", bus_a.hcount, bus_a.vcount);
        end
        total++;
        if (lows != 96 || min_h != 656 || max_h != 751) begin
            bad++; $display("FAIL hsync_width actual=%0d [%0d..%0d] required=96 [656..751]", lows, min_h, max_h);
        end
        total++;
        if (vis != 639) begin
            bad++; $display("FAIL line0_visible actual=%0d required=639", vis);
        end
    endtask

    task automatic test_frame();
        int fs_cnt = 0, vs_low = 0;
        bit fs_at_origin = 1'b1;
        for (int i = 0; i < c_b_frame + 100; i++) begin
            step(1'b0, 1'b1);
            total++;
            if (obs_b() !== exp_b()) begin
                bad++; $display("FAIL frame_b step=%0d actual=%h required=%h", i, obs_b(), exp_b());
            end
            if (bus_b.frame_start === 1'b1) begin
                fs_cnt++;
                if (bus_b.hcount !== 10'd0 || bus_b.vcount !== 10'd0) fs_at_origin = 1'b0;
            end
            if (bus_b.vsync === 1'b0) vs_low++;
        end
        total++;
        if (fs_cnt != 1 || !fs_at_origin) begin
            bad++; $display("FAIL frame_start_count actual=%0d origin=%0d required=1 origin=1", fs_cnt, fs_at_origin);
        end
        total++;
        if (vs_low != c_bv_s * c_b_ht) begin
            bad++; $display("FAIL vsync_width actual=%0d required=%0d", vs_low, c_bv_s * c_b_ht);
        end
    endtask

    task automatic test_hold();
        logic [23:0] held;
        advance_b_to(15 * c_b_ht + 30);
        held = exp_b();
        total++;
        if (obs_b() !== held) begin
            bad++; $display("FAIL hold_reach actual=%h required=%h", obs_b(), held);
        end
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            total++;
            if (obs_b() !== {held[23:1], 1'b0}) begin
                bad++; $display("FAIL hold_idle cyc=%0d actual=%h required=%h", i, obs_b(), {held[23:1], 1'b0});
            end
        end
        step(1'b0, 1'b1);
        total++;
        if (obs_b() !== exp_b() || bus_b.hcount !== 10'd31 || bus_b.vcount !== 10'd15) begin
            bad++; $display("FAIL hold_resume actual=%h required=%h", obs_b(), exp_b());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            total++;
            if (obs_a() !== exp_a()) begin
                bad++; $display("FAIL rand_a step=%0d actual=%h required=%h", i, obs_a(), exp_a());
            end
            total++;
            if (obs_b() !== exp_b()) begin
                bad++; $display("FAIL rand_b step=%0d actual=%h required=%h", i, obs_b(), exp_b());
            end
        end
    endtask

    task automatic test_mid_reset();
        advance_b_to(23 * c_b_ht + 50);
        total++;
        if (obs_b() !== exp_b() || bus_b.vsync !== 1'b0) begin
            bad++; $display("FAIL midrst_setup actual=%h required=%h", obs_b(), exp_b());
        end
        rst_b = 1'b0;
        pb = 0; arm_b = 0; fs_b = 0;
        #1;
        total++;
        if (obs_b() !== exp_b()) begin
            bad++; $display("FAIL midrst_async actual=%h required=%h", obs_b(), exp_b());
        end
        #1;
        rst_b = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        total++;
        if (obs_b() !== exp_b() || bus_b.hcount !== 10'd1 || bus_b.vcount !== 10'd0 || bus_b.video_on !== 1'b1) begin
            bad++; $display("FAIL midrst_resume actual=%h required=%h", obs_b(), exp_b());
        end
    endtask

    initial begin
        bus_a.pix_en = 1'b0;
        bus_b.pix_en = 1'b0;
        test_reset();
        test_line_wrap();
        test_frame();
        test_hold();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
